// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S multicycle control unit.
// Instruction classes, ALU op codes and control FSM states.
package k_and_s_pkg;

  typedef enum logic [4:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_XOR,
    I_BRANCH,
    I_BZERO,
    I_BNZERO,
    I_BNEG,
    I_BNNEG,
    I_BOV,
    I_BNOV,
    I_HALT
  } decoded_instruction_type;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_PASS = 4;
  localparam int OP_XOR  = 5;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM_LD,
    S_MEM_ST,
    S_BRANCH,
    S_HALTED
  } ctrl_state_t;

  function automatic int alu_op(decoded_instruction_type i);
    case (i)
      I_SUB:   return OP_SUB;
      I_AND:   return OP_AND;
      I_OR:    return OP_OR;
      I_XOR:   return OP_XOR;
      I_MOVE:  return OP_PASS;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ks_control_unit_mc_branch_cond.sv
// Branch condition evaluator: instruction class plus
// registered flags decide whether the branch is taken.
module ks_branch_cond
  import k_and_s_pkg::*;
(
  input  decoded_instruction_type cls,
  input  logic                    zero,
  input  logic                    neg,
  input  logic                    carry,
  output logic                    taken
);

  // Per-class condition table; non-branch classes never take
  always_comb begin
    taken = 1'b0;
    case (cls)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero;
      I_BNZERO: taken = !zero;
      I_BNEG:   taken = neg;
      I_BNNEG:  taken = !neg;
      I_BOV:    taken = carry;
      I_BNOV:   taken = !carry;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ks_control_unit_mc.sv
// Multicycle K&S control FSM with configurable RAM wait states.
// Optional retired-instruction counter: KS_RETIRE_COUNTER_EN.
module ks_control_unit_mc
  import k_and_s_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int OP_W     = 3,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  input  logic                    resume,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [OP_W-1:0]         operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
`ifdef KS_RETIRE_COUNTER_EN
  output logic [CNT_W-1:0]        retired_count,
`endif
  output logic                    halt
);

  localparam int WCW = 4;
  localparam logic [WCW-1:0] WAIT_INIT = WCW'(MEM_WAIT);

  ctrl_state_t             state;
  ctrl_state_t             state_next;
  logic [WCW-1:0]          cnt;
  decoded_instruction_type instr_q;
  logic                    taken;
  logic                    unused_ok;

  // BOV/BNOV test the carry flag; signed overflow is not consulted
  assign unused_ok = signed_overflow;

  ks_branch_cond u_cond (
    .cls   (instr_q),
    .zero  (zero_op),
    .neg   (neg_op),
    .carry (unsigned_overflow),
    .taken (taken)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Wait counter: reloads on every state change, counts down while held
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= WAIT_INIT;
    else if (state_next != state)
      cnt <= WAIT_INIT;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  // Capture the instruction class while decoding for later phases
  always_ff @(posedge clk) begin
    if (rst)                    instr_q <= I_NOP;
    else if (state == S_DECODE) instr_q <= decoded_instruction;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH:
        if (cnt == '0) state_next = S_DECODE;
      S_DECODE:
        case (decoded_instruction)
          I_ADD, I_SUB, I_AND,
          I_OR, I_XOR, I_MOVE:   state_next = S_EXEC;
          I_LOAD:                state_next = S_MEM_LD;
          I_STORE:               state_next = S_MEM_ST;
          I_BRANCH, I_BZERO,
          I_BNZERO, I_BNEG,
          I_BNNEG, I_BOV,
          I_BNOV:                state_next = S_BRANCH;
          I_HALT:                state_next = S_HALTED;
          default:               state_next = S_FETCH;
        endcase
      S_EXEC, S_BRANCH:
        state_next = S_FETCH;
      S_MEM_LD, S_MEM_ST:
        if (cnt == '0) state_next = S_FETCH;
      S_HALTED:
        if (resume) state_next = S_FETCH;
      default:
        state_next = S_FETCH;
    endcase
  end

  // Moore output decode; everything held low during reset
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = '0;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          addr_sel = 1'b1;
          if (cnt == '0) begin
            ir_enable = 1'b1;
            pc_enable = 1'b1;
          end
        end
        S_EXEC: begin
          operation        = OP_W'(alu_op(instr_q));
          write_reg_enable = 1'b1;
          flags_reg_enable = (instr_q != I_MOVE);
        end
        S_MEM_LD: begin
          if (cnt == '0) begin
            c_sel            = 1'b1;
            write_reg_enable = 1'b1;
          end
        end
        S_MEM_ST:
          ram_write_enable = 1'b1;
        S_BRANCH: begin
          branch    = taken;
          pc_enable = taken;
        end
        S_HALTED:
          halt = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef KS_RETIRE_COUNTER_EN
  logic [CNT_W-1:0] ret_q;
  logic             retire;

  assign retire = (state_next == S_FETCH) &&
                  (state != S_FETCH) &&
                  (state != S_HALTED);

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)         ret_q <= '0;
    else if (retire) ret_q <= ret_q + 1'b1;
  end

  assign retired_count = rst ? '0 : ret_q;
`endif

endmodule

// File: tb/tb_ks_control_unit_mc.sv
// Randomized bench for ks_control_unit_mc (MEM_WAIT=2)
// against a per-instruction phase-sequence model.
module tb_ks_control_unit_mc;
  import k_and_s_pkg::*;

  localparam int MW  = 2;
  localparam int OPW = 3;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic resume;
  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [OPW-1:0] operation;
  logic write_reg_enable, flags_reg_enable;
  logic ram_write_enable, halt;
`ifdef KS_RETIRE_COUNTER_EN
  logic [CW-1:0] retired_count;
`endif

  always #5 clk = ~clk;

  ks_control_unit_mc #(
    .MEM_WAIT (MW),
    .OP_W     (OPW),
    .CNT_W    (CW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .decoded_instruction (decoded_instruction),
    .zero_op             (zero_op),
    .neg_op              (neg_op),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow),
    .resume              (resume),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .write_reg_enable    (write_reg_enable),
    .flags_reg_enable    (flags_reg_enable),
    .ram_write_enable    (ram_write_enable),
`ifdef KS_RETIRE_COUNTER_EN
    .retired_count       (retired_count),
`endif
    .halt                (halt)
  );

  logic [11:0] vec;
  assign vec = {branch, pc_enable, ir_enable, addr_sel, c_sel,
                operation[2:0], write_reg_enable,
                flags_reg_enable, ram_write_enable, halt};

  typedef enum {
    K_FW, K_FL, K_DEC, K_EX, K_LW, K_LL, K_ST, K_BR, K_HLT
  } kind_t;

  int n_cmp = 0;
  int n_bad = 0;
  int model_ret = 0;
  int resume_pct = 0;
  int fix_flags = -1;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] expect_vec(
    kind_t k, decoded_instruction_type ins,
    logic z, logic n, logic c);
    logic b, pc, ir, a, cs, w, f, r, h;
    logic [2:0] op;
    {b, pc, ir, a, cs, w, f, r, h} = '0;
    op = 3'd0;
    case (k)
      K_FW: a = 1'b1;
      K_FL: begin a = 1'b1; ir = 1'b1; pc = 1'b1; end
      K_EX: begin
        w = 1'b1;
        case (ins)
          I_ADD:   begin op = 3'd0; f = 1'b1; end
          I_SUB:   begin op = 3'd1; f = 1'b1; end
          I_AND:   begin op = 3'd2; f = 1'b1; end
          I_OR:    begin op = 3'd3; f = 1'b1; end
          I_XOR:   begin op = 3'd5; f = 1'b1; end
          default: op = 3'd4;
        endcase
      end
      K_LL: begin cs = 1'b1; w = 1'b1; end
      K_ST: r = 1'b1;
      K_BR: begin
        case (ins)
          I_BRANCH: b = 1'b1;
          I_BZERO:  b = z;
          I_BNZERO: b = ~z;
          I_BNEG:   b = n;
          I_BNNEG:  b = ~n;
          I_BOV:    b = c;
          default:  b = ~c;
        endcase
        pc = b;
      end
      K_HLT: h = 1'b1;
      default: ;
    endcase
    return {b, pc, ir, a, cs, op, w, f, r, h};
  endfunction

  // Entered with the DUT in the first FETCH cycle, #1 after the edge
  task automatic run_instr(decoded_instruction_type ins,
                           int hlen, int abort_at);
    kind_t q[$];
    string tag;
`ifdef KS_RETIRE_COUNTER_EN
    check("retired", 32'(retired_count),
          32'(model_ret % (1 << CW)));
`endif
    for (int i = 0; i < MW; i++) q.push_back(K_FW);
    q.push_back(K_FL);
    q.push_back(K_DEC);
    case (ins)
      I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_MOVE:
        q.push_back(K_EX);
      I_LOAD: begin
        for (int i = 0; i < MW; i++) q.push_back(K_LW);
        q.push_back(K_LL);
      end
      I_STORE:
        for (int i = 0; i <= MW; i++) q.push_back(K_ST);
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
      I_BNNEG, I_BOV, I_BNOV:
        q.push_back(K_BR);
      I_HALT:
        for (int i = 0; i < hlen; i++) q.push_back(K_HLT);
      default: ;
    endcase
    decoded_instruction = ins;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (fix_flags < 0)
        {unsigned_overflow, neg_op, zero_op} = 3'($urandom);
      else
        {unsigned_overflow, neg_op, zero_op} = 3'(fix_flags);
      signed_overflow = 1'($urandom);
      if (q[i] == K_HLT)
        resume = (i == q.size() - 1);
      else
        resume = ($urandom_range(99) < 32'(resume_pct));
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_outs", 32'(vec), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        resume = 1'b0;
        model_ret = 0;
        return;
      end
      #1;
      tag = $sformatf("%s/%s/%0d", ins.name(), q[i].name(), i);
      check(tag, 32'(vec),
            32'(expect_vec(q[i], ins, zero_op, neg_op,
                           unsigned_overflow)));
    end
    @(posedge clk);
    #1;
    resume = 1'b0;
    if (ins != I_HALT) model_ret++;
  endtask

  initial begin
    int r;
    int hl;
    int ab;
    rst = 1'b1;
    decoded_instruction = I_NOP;
    {zero_op, neg_op, unsigned_overflow, signed_overflow} = '0;
    resume = 1'b0;
    @(posedge clk);
    #1;
    check("reset_outs", 32'(vec), 32'd0);
`ifdef KS_RETIRE_COUNTER_EN
    check("reset_ret", 32'(retired_count), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(I_ADD, 0, -1);
    run_instr(I_LOAD, 0, -1);
    run_instr(I_STORE, 0, -1);
    run_instr(I_MOVE, 0, -1);
    run_instr(I_XOR, 0, -1);
    fix_flags = 1;
    run_instr(I_BZERO, 0, -1);
    fix_flags = 0;
    run_instr(I_BZERO, 0, -1);
    fix_flags = -1;
    run_instr(I_HALT, 5, -1);
    resume_pct = 100;
    run_instr(I_ADD, 0, -1);
    resume_pct = 0;
    run_instr(I_STORE, 0, MW + 3);
    for (int i = 0; i < 17; i++) run_instr(I_NOP, 0, -1);
    run_instr(decoded_instruction_type'(5'd27), 0, -1);

    resume_pct = 15;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 17);
      hl = $urandom_range(1, 6);
      ab = ($urandom_range(29) == 0) ? $urandom_range(0, 8) : -1;
      if (r == 17)
        run_instr(decoded_instruction_type'(5'd29), hl, ab);
      else
        run_instr(decoded_instruction_type'(5'(r)), hl, ab);
    end
    run_instr(I_NOP, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ks_control_unit_mc.md
Name: ks_control_unit_mc

Overview:
- Parametrised multicycle control FSM for the K&S processor, successor of the fixed single-wait control unit.
- Sits between the decoder and the datapath. It sequences fetch, decode, execute, memory and branch phases.
- Adds three features over the previous unit: a configurable RAM wait-state count, a wider ALU operation field (adds XOR), and a resumable HALT state.

Parameters:
- MEM_WAIT, 1, extra cycles a RAM access is held (legal 0..15); each access lasts MEM_WAIT+1 cycles.
- OP_W, 3, width of the ALU operation field (minimum 3).
- CNT_W, 32, width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- decoded_instruction  in  decoded_instruction_type  instruction class from the decoder
- zero_op  in  1  registered zero flag
- neg_op  in  1  registered negative flag
- unsigned_overflow  in  1  registered carry flag
- signed_overflow  in  1  registered overflow flag
- resume  in  1  single-cycle pulse that leaves HALTED
- branch  out  1  PC mux selects branch target
- pc_enable  out  1  PC load
- ir_enable  out  1  IR load
- addr_sel  out  1  1 = PC drives RAM address, 0 = data address
- c_sel  out  1  1 = RAM data to register write port, 0 = ALU result
- operation  out  OP_W  ALU operation code
- write_reg_enable  out  1  register file write
- flags_reg_enable  out  1  flags register load
- ram_write_enable  out  1  RAM write strobe
- halt  out  1  processor halted

Behaviour:
- Reset:
  - With rst=1 at a clk edge, state←FETCH and wait counter←MEM_WAIT.
  - While rst=1, all outputs are forced to 0.
  - Reset asserted mid-operation aborts the phase in progress; no write strobe is issued in the reset cycle.
- Outputs are Moore-decoded from state and counter; unlisted outputs are 0.
- States: FETCH, DECODE, EXEC, MEM_LD, MEM_ST, BRANCH, HALTED.
- FETCH:
  - addr_sel=1 for MEM_WAIT+1 cycles; counter decrements each cycle.
  - In the cycle where counter==0: ir_enable=1, pc_enable=1 (branch=0), then →DECODE.
- DECODE (one cycle, all outputs 0):
  - ADD/SUB/AND/OR/XOR/MOVE → EXEC.
  - LOAD → MEM_LD.
  - STORE → MEM_ST.
  - BRANCH/BZERO/BNZERO/BNEG/BNNEG/BOV/BNOV → BRANCH.
  - HALT → HALTED.
  - NOP → FETCH.
  - Entering MEM_LD or MEM_ST reloads the counter to MEM_WAIT.
- EXEC (one cycle):
  - operation = OP code of the instruction; write_reg_enable=1; c_sel=0.
  - flags_reg_enable=1 except for MOVE (OP_PASS).
  - Then → FETCH.
- MEM_LD:
  - addr_sel=0 for MEM_WAIT+1 cycles.
  - Final cycle: c_sel=1, write_reg_enable=1, then → FETCH.
- MEM_ST:
  - addr_sel=0 and ram_write_enable=1 held for all MEM_WAIT+1 cycles, then → FETCH.
- BRANCH (one cycle):
  - Condition per class: BRANCH always taken; BZERO zero_op; BNZERO !zero_op; BNEG neg_op; BNNEG !neg_op; BOV unsigned_overflow; BNOV !unsigned_overflow.
  - Taken: branch=1, pc_enable=1. Not taken: both 0.
  - Then → FETCH.
- HALTED:
  - halt=1.
  - resume=1 → FETCH next cycle (counter←MEM_WAIT); otherwise stay.
  - resume outside HALTED is ignored.
- Flags are sampled only in the BRANCH cycle; flag changes elsewhere have no effect.
- MEM_WAIT=0: every memory phase is a single cycle; the counter never underflows.
- Unknown decoded class is treated as NOP.

Optional Feature:
- Macro: KS_RETIRE_COUNTER_EN.
- Defined:
  - Adds output retired_count [CNT_W-1:0], reset to 0.
  - Increments by 1 on each transition into FETCH from DECODE, EXEC, MEM_LD, MEM_ST or BRANCH. HALTED→FETCH does not count.
  - Wraps modulo 2^CNT_W.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- k_and_s_pkg holds:
  - decoded_instruction_type enum, extended with I_XOR and I_BNOV.
  - ALU op localparams: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_PASS=4, OP_XOR=5.
  - ctrl_state_t enum.
- One sub-module: ks_branch_cond, a combinational condition evaluator (class plus flags → taken).

Test Plan:
- MEM_WAIT=2, ADD after reset → FETCH lasts 3 cycles with addr_sel=1; ir_enable/pc_enable in cycle 3; DECODE; EXEC has operation=0, write_reg_enable=1, flags_reg_enable=1; 5 cycles total.
- LOAD, MEM_WAIT=0 → MEM_LD is 1 cycle with addr_sel=0, c_sel=1, write_reg_enable=1; STORE → ram_write_enable=1 for exactly 1 cycle.
- BZERO with zero_op=1 → branch=1, pc_enable=1 in the BRANCH cycle; with zero_op=0 → both 0; zero_op toggled during EXEC has no effect.
- HALT, then resume pulsed 5 cycles later → halt=1 for 5 cycles, then FETCH; a resume pulse during FETCH has no effect.
- rst=1 during MEM_ST cycle 2 of 3 → ram_write_enable=0 in the reset cycle; next state FETCH; all outputs 0.
- KS_RETIRE_COUNTER_EN defined, CNT_W=4, 17 NOPs executed → retired_count=1 (wrap).
